// File: rtl/iobus_pkg.sv
// Shared constants, FSM state type and strobe indices for the IO bus connector
// and related bus bridges.
package iobus_pkg;

    localparam int IOB_W   = 36;
    localparam int PI_W    = 7;
    localparam int IOS_W   = 7;
    localparam int SEL_W   = 4;
    localparam int MAX_NS  = 16;
    localparam int NUM_STB = 9;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    // Bit positions of the master strobes inside the packed strobe vector.
    localparam int STB_POWERON     = 0;
    localparam int STB_RESET       = 1;
    localparam int STB_DATAO_CLEAR = 2;
    localparam int STB_DATAO_SET   = 3;
    localparam int STB_CONO_CLEAR  = 4;
    localparam int STB_CONO_SET    = 5;
    localparam int STB_FM_DATAI    = 6;
    localparam int STB_FM_STATUS   = 7;
    localparam int STB_RDI_PULSE   = 8;

    // Strobes that open or sustain a command transfer.
    localparam logic [NUM_STB-1:0] CMD_MASK = 9'b1_1111_1100;

endpackage

// File: rtl/iobus_decode.sv
// Device-code decoder: compares a device code against a table of NS codes and
// returns the hit vector plus the lowest matching index. Purely combinational.
module iobus_decode
    import iobus_pkg::*;
#(
    parameter int                        NS       = 4,
    parameter logic [MAX_NS*IOS_W-1:0]   DEVCODES = '0
) (
    input  logic [IOS_W-1:0] ios,
    output logic [NS-1:0]    hit,
    output logic [SEL_W-1:0] sel,
    output logic             valid
);

    for (genvar gi = 0; gi < NS; gi++) begin : g_cmp
        assign hit[gi] = (ios == DEVCODES[gi*IOS_W +: IOS_W]);
    end

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        sel = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel = SEL_W'(k);
            end
        end
    end

    assign valid = |hit;

endmodule

// File: rtl/iobus_n_connect.sv
// Registered connector between one IO bus master and NS slave devices.
// Build option: define IOBUS_NODEV_EN for the no-device flag and floating-bus reads.
module iobus_n_connect
    import iobus_pkg::*;
#(
    parameter int                      NS          = 4,
    parameter logic [MAX_NS*IOS_W-1:0] DEVCODES    = '0,
    parameter bit                      BCAST_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_iob_poweron,
    input  logic              m_iob_reset,
    input  logic              m_datao_clear,
    input  logic              m_datao_set,
    input  logic              m_cono_clear,
    input  logic              m_cono_set,
    input  logic              m_iob_fm_datai,
    input  logic              m_iob_fm_status,
    input  logic              m_rdi_pulse,
    input  logic [3:9]        m_ios,
    input  logic [0:35]       m_iob_write,
    output logic [1:7]        m_pi_req,
    output logic [0:35]       m_iob_read,
    output logic              m_dr_split,
    output logic              m_rdi_data,
    output logic              m_nodev,
    output logic [0:NS-1]     s_iob_poweron,
    output logic [0:NS-1]     s_iob_reset,
    output logic [0:NS-1]     s_datao_clear,
    output logic [0:NS-1]     s_datao_set,
    output logic [0:NS-1]     s_cono_clear,
    output logic [0:NS-1]     s_cono_set,
    output logic [0:NS-1]     s_iob_fm_datai,
    output logic [0:NS-1]     s_iob_fm_status,
    output logic [0:NS-1]     s_rdi_pulse,
    output logic [3:9]        s_ios,
    output logic [0:35]       s_iob_write,
    input  logic [0:NS*7-1]   s_pi_req,
    input  logic [0:NS*36-1]  s_iob_read,
    input  logic [0:NS-1]     s_dr_split,
    input  logic [0:NS-1]     s_rdi_data
);

`ifdef IOBUS_NODEV_EN
    localparam bit NODEV_EN = 1'b1;
`else
    localparam bit NODEV_EN = 1'b0;
`endif
    localparam logic [0:IOB_W-1] MISS_CAP = NODEV_EN ? '1 : '0;

    logic [NUM_STB-1:0]           m_stb;
    logic                         cmd;
    logic                         rd;
    logic [NS-1:0]                hit;
    logic [NS-1:0]                first_hit;
    logic [SEL_W-1:0]             win_sel;
    logic                         win_valid;
    state_e                       state_q, state_d;
    logic [SEL_W-1:0]             sel_q, sel_d, route_sel;
    logic                         valid_q, valid_d, route_valid;
    logic                         nodev_q, nodev_d;
    logic [0:IOB_W-1]             cap_q, cap_d, slave_rd;
    logic [0:NS-1]                route_mask;
    logic [NUM_STB-1:0][0:NS-1]   stb_q, stb_d;
    logic [3:9]                   ios_q;
    logic [0:IOB_W-1]             wr_q;
    logic [1:PI_W]                pi_q, pi_d;
    logic                         dr_q, dr_d, rdi_q, rdi_d;

    assign m_stb[STB_POWERON]     = m_iob_poweron;
    assign m_stb[STB_RESET]       = m_iob_reset;
    assign m_stb[STB_DATAO_CLEAR] = m_datao_clear;
    assign m_stb[STB_DATAO_SET]   = m_datao_set;
    assign m_stb[STB_CONO_CLEAR]  = m_cono_clear;
    assign m_stb[STB_CONO_SET]    = m_cono_set;
    assign m_stb[STB_FM_DATAI]    = m_iob_fm_datai;
    assign m_stb[STB_FM_STATUS]   = m_iob_fm_status;
    assign m_stb[STB_RDI_PULSE]   = m_rdi_pulse;

    assign cmd = |(m_stb & CMD_MASK);
    assign rd  = m_iob_fm_datai | m_iob_fm_status;

    iobus_decode #(
        .NS       (NS),
        .DEVCODES (DEVCODES)
    ) u_decode (
        .ios   (m_ios),
        .hit   (hit),
        .sel   (win_sel),
        .valid (win_valid)
    );

    // Isolate the lowest set bit: the one-hot form of the winning slave.
    assign first_hit = hit & (~hit + NS'(1));

    // Route through the latched slave once a transfer is open, else the live decode.
    always_comb begin
        route_mask = '0;
        if (state_q == XFER) begin
            route_sel   = sel_q;
            route_valid = valid_q;
            for (int k = 0; k < NS; k++) begin
                route_mask[k] = valid_q && (sel_q == SEL_W'(k));
            end
        end else begin
            route_sel   = win_sel;
            route_valid = win_valid;
            for (int k = 0; k < NS; k++) begin
                route_mask[k] = first_hit[k];
            end
        end
        slave_rd = '0;
        for (int k = 0; k < NS; k++) begin
            if (route_sel == SEL_W'(k)) begin
                slave_rd = s_iob_read[k*IOB_W +: IOB_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        nodev_d = nodev_q;
        cap_d   = cap_q;
        if (state_q == IDLE) begin
            if (cmd) begin
                state_d = XFER;
                sel_d   = win_sel;
                valid_d = win_valid;
                nodev_d = NODEV_EN && !win_valid;
            end
        end else if (!cmd) begin
            state_d = IDLE;
            cap_d   = '0;
        end
        if (cmd && rd) begin
            cap_d = route_valid ? slave_rd : MISS_CAP;
        end
        if (m_iob_reset) begin
            state_d = IDLE;
            cap_d   = '0;
            nodev_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_STB; i++) begin
            if (BCAST_RESET && (i == STB_POWERON || i == STB_RESET)) begin
                stb_d[i] = {NS{m_stb[i]}};
            end else if (CMD_MASK[i]) begin
                stb_d[i] = m_iob_reset ? '0 : (route_mask & {NS{m_stb[i]}});
            end else begin
                stb_d[i] = route_mask & {NS{m_stb[i]}};
            end
        end
        pi_d = '0;
        for (int k = 0; k < NS; k++) begin
            pi_d = pi_d | s_pi_req[k*PI_W +: PI_W];
        end
        dr_d  = |s_dr_split;
        rdi_d = |s_rdi_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            nodev_q <= 1'b0;
            cap_q   <= '0;
            stb_q   <= '0;
            ios_q   <= '0;
            wr_q    <= '0;
            pi_q    <= '0;
            dr_q    <= 1'b0;
            rdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            nodev_q <= nodev_d;
            cap_q   <= cap_d;
            stb_q   <= stb_d;
            ios_q   <= m_ios;
            wr_q    <= m_iob_write;
            pi_q    <= pi_d;
            dr_q    <= dr_d;
            rdi_q   <= rdi_d;
        end
    end

    assign s_iob_poweron   = stb_q[STB_POWERON];
    assign s_iob_reset     = stb_q[STB_RESET];
    assign s_datao_clear   = stb_q[STB_DATAO_CLEAR];
    assign s_datao_set     = stb_q[STB_DATAO_SET];
    assign s_cono_clear    = stb_q[STB_CONO_CLEAR];
    assign s_cono_set      = stb_q[STB_CONO_SET];
    assign s_iob_fm_datai  = stb_q[STB_FM_DATAI];
    assign s_iob_fm_status = stb_q[STB_FM_STATUS];
    assign s_rdi_pulse     = stb_q[STB_RDI_PULSE];

    assign s_ios       = ios_q;
    assign s_iob_write = wr_q;
    assign m_pi_req    = pi_q;
    assign m_dr_split  = dr_q;
    assign m_rdi_data  = rdi_q;
    assign m_nodev     = nodev_q;
    assign m_iob_read  = m_iob_write | cap_q;

endmodule

// File: tb/tb_iobus_n_connect.sv
// Self-checking bench for iobus_n_connect: command-burst model plus directed
// vectors with literal expectations; follows IOBUS_NODEV_EN when defined.
module tb_iobus_n_connect;

    localparam int NS = 4;
    localparam logic [111:0] CODES = {84'd0, 7'o124, 7'o120, 7'o070, 7'o014};
`ifdef IOBUS_NODEV_EN
    localparam bit NODEV = 1'b1;
`else
    localparam bit NODEV = 1'b0;
`endif

    int table_codes [NS] = '{'o014, 'o070, 'o120, 'o124};
    string stb_names [9] = '{"s_iob_poweron", "s_iob_reset", "s_datao_clear", "s_datao_set",
                             "s_cono_clear", "s_cono_set", "s_iob_fm_datai", "s_iob_fm_status",
                             "s_rdi_pulse"};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic m_iob_poweron, m_iob_reset, m_datao_clear, m_datao_set, m_cono_clear, m_cono_set;
    logic m_iob_fm_datai, m_iob_fm_status, m_rdi_pulse;
    logic [3:9]       m_ios;
    logic [0:35]      m_iob_write;
    logic [1:7]       m_pi_req;
    logic [0:35]      m_iob_read;
    logic             m_dr_split, m_rdi_data, m_nodev;
    logic [0:NS-1]    s_iob_poweron, s_iob_reset, s_datao_clear, s_datao_set, s_cono_clear;
    logic [0:NS-1]    s_cono_set, s_iob_fm_datai, s_iob_fm_status, s_rdi_pulse;
    logic [3:9]       s_ios;
    logic [0:35]      s_iob_write;
    logic [0:NS*7-1]  s_pi_req;
    logic [0:NS*36-1] s_iob_read;
    logic [0:NS-1]    s_dr_split, s_rdi_data;

    iobus_n_connect #(
        .NS          (NS),
        .DEVCODES    (CODES),
        .BCAST_RESET (1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .m_iob_poweron   (m_iob_poweron),
        .m_iob_reset     (m_iob_reset),
        .m_datao_clear   (m_datao_clear),
        .m_datao_set     (m_datao_set),
        .m_cono_clear    (m_cono_clear),
        .m_cono_set      (m_cono_set),
        .m_iob_fm_datai  (m_iob_fm_datai),
        .m_iob_fm_status (m_iob_fm_status),
        .m_rdi_pulse     (m_rdi_pulse),
        .m_ios           (m_ios),
        .m_iob_write     (m_iob_write),
        .m_pi_req        (m_pi_req),
        .m_iob_read      (m_iob_read),
        .m_dr_split      (m_dr_split),
        .m_rdi_data      (m_rdi_data),
        .m_nodev         (m_nodev),
        .s_iob_poweron   (s_iob_poweron),
        .s_iob_reset     (s_iob_reset),
        .s_datao_clear   (s_datao_clear),
        .s_datao_set     (s_datao_set),
        .s_cono_clear    (s_cono_clear),
        .s_cono_set      (s_cono_set),
        .s_iob_fm_datai  (s_iob_fm_datai),
        .s_iob_fm_status (s_iob_fm_status),
        .s_rdi_pulse     (s_rdi_pulse),
        .s_ios           (s_ios),
        .s_iob_write     (s_iob_write),
        .s_pi_req        (s_pi_req),
        .s_iob_read      (s_iob_read),
        .s_dr_split      (s_dr_split),
        .s_rdi_data      (s_rdi_data)
    );

    logic [0:NS-1] act_stb [9];
    assign act_stb[0] = s_iob_poweron;
    assign act_stb[1] = s_iob_reset;
    assign act_stb[2] = s_datao_clear;
    assign act_stb[3] = s_datao_set;
    assign act_stb[4] = s_cono_clear;
    assign act_stb[5] = s_cono_set;
    assign act_stb[6] = s_iob_fm_datai;
    assign act_stb[7] = s_iob_fm_status;
    assign act_stb[8] = s_rdi_pulse;

    int checks   = 0;
    int failures = 0;
    bit run_checks = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [6:0] code);
        for (int k = 0; k < NS; k++) begin
            if (int'(code) == table_codes[k]) return k;
        end
        return -1;
    endfunction

    // Model state: an open command burst targets one slave (or none) until all command strobes fall.
    bit            in_cmd;
    int            tgt;
    logic          e_nodev, e_dr, e_rdi;
    logic [0:35]   e_cap, e_wr;
    logic [1:7]    e_pi;
    logic [3:9]    e_ios;
    logic [0:NS-1] e_stb [9];

    always @(posedge clk) begin : model
        logic [8:0]    mst;
        logic [0:6]    pi;
        logic [0:NS-1] nstb [9];
        logic [0:35]   ncap;
        logic          any_cmd, rd, nnodev;
        bit            nin;
        int            ntgt;
        mst = {m_rdi_pulse, m_iob_fm_status, m_iob_fm_datai, m_cono_set, m_cono_clear,
               m_datao_set, m_datao_clear, m_iob_reset, m_iob_poweron};
        any_cmd = |mst[8:2];
        rd      = m_iob_fm_datai | m_iob_fm_status;
        nin = in_cmd; ntgt = tgt; nnodev = e_nodev; ncap = e_cap;
        for (int i = 0; i < 9; i++) nstb[i] = '0;
        pi = '0;
        if (reset) begin
            nin = 1'b0; ntgt = -1; nnodev = 1'b0; ncap = '0;
            e_ios <= '0; e_wr <= '0; e_pi <= '0; e_dr <= 1'b0; e_rdi <= 1'b0;
        end else begin
            for (int k = 0; k < NS; k++) pi = pi | s_pi_req[k*7 +: 7];
            e_ios <= m_ios; e_wr <= m_iob_write; e_pi <= pi;
            e_dr  <= |s_dr_split; e_rdi <= |s_rdi_data;
            nstb[0] = {NS{m_iob_poweron}};
            nstb[1] = {NS{m_iob_reset}};
            if (m_iob_reset) begin
                nin = 1'b0; ncap = '0; nnodev = 1'b0;
            end else if (any_cmd) begin
                if (!nin) begin
                    ntgt = lookup(m_ios); nin = 1'b1; nnodev = NODEV && (ntgt < 0);
                end
                if (ntgt >= 0) begin
                    for (int i = 2; i < 9; i++) nstb[i][ntgt] = mst[i];
                end
                if (rd) ncap = (ntgt >= 0) ? s_iob_read[ntgt*36 +: 36] : (NODEV ? {36{1'b1}} : 36'd0);
            end else begin
                nin = 1'b0; ncap = '0;
            end
        end
        in_cmd <= nin; tgt <= ntgt; e_nodev <= nnodev; e_cap <= ncap;
        for (int i = 0; i < 9; i++) e_stb[i] <= nstb[i];
    end

    always @(negedge clk) begin
        if (run_checks) begin
            chk("m_pi_req", 64'(m_pi_req), 64'(e_pi));
            chk("m_dr_split", 64'(m_dr_split), 64'(e_dr));
            chk("m_rdi_data", 64'(m_rdi_data), 64'(e_rdi));
            chk("m_nodev", 64'(m_nodev), 64'(e_nodev));
            chk("s_ios", 64'(s_ios), 64'(e_ios));
            chk("s_iob_write", 64'(s_iob_write), 64'(e_wr));
            chk("m_iob_read", 64'(m_iob_read), 64'(m_iob_write | e_cap));
            for (int i = 0; i < 9; i++) chk(stb_names[i], 64'(act_stb[i]), 64'(e_stb[i]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {m_iob_poweron, m_iob_reset, m_datao_clear, m_datao_set, m_cono_clear, m_cono_set} = '0;
        {m_iob_fm_datai, m_iob_fm_status, m_rdi_pulse} = '0;
        m_ios = '0; m_iob_write = '0;
        s_pi_req = '0; s_iob_read = '0; s_dr_split = '0; s_rdi_data = '0;
        step();
        run_checks = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("reset_nodev", 64'(m_nodev), 64'd0);
        chk("reset_read", 64'(m_iob_read), 64'd0);
        chk("reset_cono_set", 64'(s_cono_set), 64'd0);

        // cono_set to o070 for three cycles
        m_ios = 7'o070; m_cono_set = 1'b1;
        step();
        chk("t1_first", 64'(s_cono_set), 64'(4'b0100));
        step(); step();
        chk("t1_third", 64'(s_cono_set), 64'(4'b0100));
        chk("t1_nodev", 64'(m_nodev), 64'd0);
        m_cono_set = 1'b0;
        step();
        chk("t1_drop", 64'(s_cono_set), 64'd0);

        // datai from slave 2
        s_iob_read[72 +: 36] = 36'o123456701234;
        m_iob_write = 36'o400000000000;
        m_ios = 7'o120; m_iob_fm_datai = 1'b1;
        step();
        chk("t2_read", 64'(m_iob_read), 64'(36'o523456701234));
        chk("t2_strobe", 64'(s_iob_fm_datai), 64'(4'b0010));
        m_iob_fm_datai = 1'b0;
        step();
        chk("t2_idle_read", 64'(m_iob_read), 64'(36'o400000000000));
        m_iob_write = '0;

        // interrupt / dr_split OR
        s_pi_req[0 +: 7] = 7'b0000100; s_pi_req[21 +: 7] = 7'b1000000;
        s_dr_split = 4'b0010; s_rdi_data = 4'b0001;
        step();
        chk("t3_pi", 64'(m_pi_req), 64'(7'b1000100));
        s_pi_req = '0; s_dr_split = '0; s_rdi_data = '0;
        step();

        // unmapped device code
        m_ios = 7'o177; m_cono_clear = 1'b1;
        step();
        chk("t4_nodev", 64'(m_nodev), 64'(NODEV));
        chk("t4_no_strobe", 64'(s_cono_clear), 64'd0);
        m_cono_clear = 1'b0;
        step();
        m_iob_fm_datai = 1'b1;
        step();
        chk("t4_float_read", 64'(m_iob_read), NODEV ? 64'(36'o777777777777) : 64'd0);
        m_iob_fm_datai = 1'b0;
        step();
        m_ios = 7'o014; m_cono_set = 1'b1;
        step();
        chk("t4_nodev_clr", 64'(m_nodev), 64'd0);
        m_cono_set = 1'b0;
        step();

        // ios change mid-transfer keeps slave 0
        m_ios = 7'o014; m_cono_set = 1'b1;
        step();
        m_ios = 7'o070;
        step(); step();
        chk("t5_latched", 64'(s_cono_set), 64'(4'b1000));
        m_cono_set = 1'b0;
        step();
        chk("t5_drop", 64'(s_cono_set), 64'd0);

        // reset mid datao_set
        m_ios = 7'o124; m_datao_set = 1'b1; m_iob_write = 36'o12345;
        step();
        chk("t6_strobe", 64'(s_datao_set), 64'(4'b0001));
        reset = 1'b1;
        step();
        chk("t6_reset_strobe", 64'(s_datao_set), 64'd0);
        chk("t6_reset_read", 64'(m_iob_read), 64'(36'o12345));
        reset = 1'b0; m_datao_set = 1'b0;
        step();

        // bus reset broadcast clears nodev
        m_ios = 7'o177; m_cono_set = 1'b1;
        step();
        m_iob_reset = 1'b1; m_iob_poweron = 1'b1;
        step();
        chk("t7_bcast", 64'(s_iob_reset), 64'(4'b1111));
        chk("t7_nodev", 64'(m_nodev), 64'd0);
        m_iob_reset = 1'b0; m_iob_poweron = 1'b0; m_cono_set = 1'b0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
